pixel_serializer: RTL and testbench
===================================

Name: pixel_serializer

Overview:
Consumer end of the character generator's row interface.
- Accepts one 8-pixel character row plus its colour/blink/conceal attributes through a valid/ready load port.
- Double-buffers the row (hold register + shift register).
- Shifts the row out one pixel per pixel-enable as a 3-bit videotex colour index to the VGA colour/DAC stage.
- Applies blink timing, conceal and blanking.

Parameters:
PIXELS_PER_CHAR, 8, pixels per row word; row word width.
COLOR_WIDTH, 3, colour index width (8 videotex colours).
BLINK_FRAMES, 32, frame_start pulses per blink half-period; power of two, at least 2.

Ports:
clk  in  1  system clock.
reset  in  1  asynchronous, active-high reset.
pixel_enable  in  1  advance one pixel this cycle.
display_enable  in  1  high inside the visible area; low forces blanking.
frame_start  in  1  one-cycle pulse per frame.
load_valid  in  1  row word and attributes are valid.
load_ready  out  1  hold register is empty.
row_pixels  in  PIXELS_PER_CHAR  row design; bit 7 is the leftmost pixel.
foreground  in  COLOR_WIDTH  colour for set pixels.
background  in  COLOR_WIDTH  colour for clear pixels.
blink  in  1  blink attribute.
conceal  in  1  conceal attribute.
pixel_valid  out  1  pixel_color is a visible pixel this cycle.
pixel_color  out  COLOR_WIDTH  output colour index.
underrun  out  1  one-cycle pulse: shifter needed data but hold was empty.

Behaviour:
Reset (asynchronous, active-high):
- Clears hold, shift register, bit counter and blink state.
- Outputs: load_ready=1, pixel_valid=0, pixel_color=0, underrun=0.

Load port:
- Transfer occurs when load_valid & load_ready on a rising clk.
- A transfer captures row_pixels and all attributes into hold and sets hold_full.
- load_ready = !hold_full, registered; no combinational path from pixel_enable.

Shifter:
- State: empty/busy flag plus a 3-bit index counter (7 down to 0).
- On pixel_enable with shifter busy: emit bit[index], then decrement index.
- At index 0 with pixel_enable: if hold_full, move hold into the shifter (index=7), clear hold_full, and set load_ready next cycle. Otherwise the shifter goes empty.
- On pixel_enable with shifter empty: if hold_full, load and emit bit 7 in the same cycle (index becomes 6). Otherwise emit colour 0 and pulse underrun, but only if display_enable=1.
- If a new load and the hold→shift move coincide, the move wins; the load is impossible because load_ready was 0.

Colour selection (all registered, 1-cycle latency after the pixel_enable cycle):
- display_enable=0 → pixel_color=0, pixel_valid=0. Shifting still advances.
- conceal=1, or (blink=1 and blink_phase=1) → background.
- Otherwise: bit set → foreground, clear → background.
- pixel_valid = registered (pixel_enable & display_enable).
- With pixel_enable=0, pixel_color holds its last value and pixel_valid=0.

Blink timer:
- log2(BLINK_FRAMES)-bit counter incremented on each frame_start.
- blink_phase toggles on wrap from BLINK_FRAMES-1 to 0.
- blink_phase affects pixels emitted from the next cycle onward.

Boundary conditions:
- frame_start coincident with pixel_enable: both take effect.
- Reset mid-row: the row is discarded and the next load restarts at bit 7.
- display_enable falling mid-row does not flush the shifter.

Decomposition:
- Shared include constant.vh gains COLOR_WIDTH, PIXELS_PER_CHAR, BLINK_FRAMES defaults and a COLOR_RANGE macro.
- One sub-module, blink_timer (frame counter + blink_phase), reused later by the cursor logic.
- Shifter, hold register and colour mux stay in pixel_serializer.

Test Plan:
- Reset then load row 8'hA5 with fg=7, bg=1 and continuous pixel_enable → pixel_color sequence 7,1,7,1,1,7,1,7 starting 1 cycle after the first enable; load_ready back to 1 one cycle after the shifter takes the row.
- Back-to-back rows 8'hFF then 8'h00 with the second loaded during the first → 16 contiguous pixels (8×fg, then 8×bg), no underrun.
- No load after one row, pixel_enable kept high, display_enable=1 → 9th pixel is colour 0 with a single-cycle underrun pulse.
- blink=1, BLINK_FRAMES=2, row 8'hFF fg=3 bg=4; pulse frame_start twice → pixels switch from 3 to 4, and return to 3 after 2 more pulses.
- conceal=1 with row 8'hFF fg=6 bg=2 → all 2; display_enable=0 mid-row → pixel_color=0 and pixel_valid=0, remaining bits consumed.
- Assert reset at pixel 4 of a row → outputs zero immediately; after release, a new row 8'h80 emits fg first.

Source files
------------

// File: rtl/pixel_serializer_pkg.sv
// Shared defaults and types for the pixel serializer and its blink timer.
// The blink timer is kept generic so the cursor logic can reuse it.
package pixel_serializer_pkg;

  localparam int PIXELS_PER_CHAR_DEFAULT = 8;
  localparam int COLOR_WIDTH_DEFAULT     = 3;
  localparam int BLINK_FRAMES_DEFAULT    = 32;

  typedef enum logic {
    SHIFT_EMPTY = 1'b0,
    SHIFT_BUSY  = 1'b1
  } shift_state_t;

endpackage

// File: rtl/pixel_serializer_blink_timer.sv
// Frame counter that toggles blink_phase every BLINK_FRAMES frame_start pulses.
// BLINK_FRAMES must be a power of two so the counter wraps on its own.
module blink_timer
  import pixel_serializer_pkg::*;
#(
  parameter int BLINK_FRAMES = BLINK_FRAMES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic frame_start,
  output logic blink_phase
);

  localparam int CW = $clog2(BLINK_FRAMES);

  logic [CW-1:0] frame_count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      frame_count <= '0;
      blink_phase <= 1'b0;
    end else if (frame_start) begin
      frame_count <= frame_count + CW'(1);
      if (frame_count == CW'(BLINK_FRAMES - 1)) begin
        blink_phase <= ~blink_phase;
      end
    end
  end

endmodule

// File: rtl/pixel_serializer.sv
// Double-buffered character-row serializer: hold register feeds a shift register
// that emits one colour index per pixel_enable, with blink, conceal and blanking.
module pixel_serializer
  import pixel_serializer_pkg::*;
#(
  parameter int PIXELS_PER_CHAR = PIXELS_PER_CHAR_DEFAULT,
  parameter int COLOR_WIDTH     = COLOR_WIDTH_DEFAULT,
  parameter int BLINK_FRAMES    = BLINK_FRAMES_DEFAULT
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       pixel_enable,
  input  logic                       display_enable,
  input  logic                       frame_start,
  input  logic                       load_valid,
  output logic                       load_ready,
  input  logic [PIXELS_PER_CHAR-1:0] row_pixels,
  input  logic [COLOR_WIDTH-1:0]     foreground,
  input  logic [COLOR_WIDTH-1:0]     background,
  input  logic                       blink,
  input  logic                       conceal,
  output logic                       pixel_valid,
  output logic [COLOR_WIDTH-1:0]     pixel_color,
  output logic                       underrun
);

  localparam int IW = $clog2(PIXELS_PER_CHAR);
  localparam logic [IW-1:0] LAST_INDEX = IW'(PIXELS_PER_CHAR - 1);

  logic                       hold_full;
  logic [PIXELS_PER_CHAR-1:0] hold_pixels;
  logic [COLOR_WIDTH-1:0]     hold_fg;
  logic [COLOR_WIDTH-1:0]     hold_bg;
  logic                       hold_blink;
  logic                       hold_conceal;

  shift_state_t               state;
  shift_state_t               next_state;
  logic [IW-1:0]              index;
  logic [IW-1:0]              next_index;
  logic [PIXELS_PER_CHAR-1:0] shift_pixels;
  logic [COLOR_WIDTH-1:0]     shift_fg;
  logic [COLOR_WIDTH-1:0]     shift_bg;
  logic                       shift_blink;
  logic                       shift_conceal;

  logic                       take_hold;
  logic                       emit;
  logic                       emit_bit;
  logic [COLOR_WIDTH-1:0]     emit_fg;
  logic [COLOR_WIDTH-1:0]     emit_bg;
  logic                       emit_blink;
  logic                       emit_conceal;
  logic                       starving;
  logic                       blink_phase;
  logic                       load_fire;

  blink_timer #(
    .BLINK_FRAMES(BLINK_FRAMES)
  ) u_blink_timer (
    .clk         (clk),
    .reset       (reset),
    .frame_start (frame_start),
    .blink_phase (blink_phase)
  );

  // hold_full is a flop, so load_ready never depends combinationally on pixel_enable
  assign load_ready = ~hold_full;
  assign load_fire  = load_valid & ~hold_full;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_full    <= 1'b0;
      hold_pixels  <= '0;
      hold_fg      <= '0;
      hold_bg      <= '0;
      hold_blink   <= 1'b0;
      hold_conceal <= 1'b0;
    end else if (load_fire) begin
      hold_full    <= 1'b1;
      hold_pixels  <= row_pixels;
      hold_fg      <= foreground;
      hold_bg      <= background;
      hold_blink   <= blink;
      hold_conceal <= conceal;
    end else if (take_hold) begin
      hold_full    <= 1'b0;
    end
  end

  // An empty shifter fed from hold emits the hold row's first pixel in the same cycle
  always_comb begin
    next_state   = state;
    next_index   = index;
    take_hold    = 1'b0;
    emit         = 1'b0;
    emit_bit     = shift_pixels[index];
    emit_fg      = shift_fg;
    emit_bg      = shift_bg;
    emit_blink   = shift_blink;
    emit_conceal = shift_conceal;
    starving     = 1'b0;
    if (pixel_enable) begin
      case (state)
        SHIFT_BUSY: begin
          emit = 1'b1;
          if (index == '0) begin
            if (hold_full) begin
              take_hold  = 1'b1;
              next_index = LAST_INDEX;
            end else begin
              next_state = SHIFT_EMPTY;
            end
          end else begin
            next_index = index - 1'b1;
          end
        end
        SHIFT_EMPTY: begin
          if (hold_full) begin
            take_hold    = 1'b1;
            emit         = 1'b1;
            emit_bit     = hold_pixels[PIXELS_PER_CHAR-1];
            emit_fg      = hold_fg;
            emit_bg      = hold_bg;
            emit_blink   = hold_blink;
            emit_conceal = hold_conceal;
            next_state   = SHIFT_BUSY;
            next_index   = LAST_INDEX - 1'b1;
          end else begin
            starving = 1'b1;
          end
        end
        default: begin
          next_state = SHIFT_EMPTY;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= SHIFT_EMPTY;
      index         <= '0;
      shift_pixels  <= '0;
      shift_fg      <= '0;
      shift_bg      <= '0;
      shift_blink   <= 1'b0;
      shift_conceal <= 1'b0;
    end else begin
      state <= next_state;
      index <= next_index;
      if (take_hold) begin
        shift_pixels  <= hold_pixels;
        shift_fg      <= hold_fg;
        shift_bg      <= hold_bg;
        shift_blink   <= hold_blink;
        shift_conceal <= hold_conceal;
      end
    end
  end

  // Blanking still lets the shifter advance; only the visible colour is forced to 0
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pixel_valid <= 1'b0;
      pixel_color <= '0;
      underrun    <= 1'b0;
    end else begin
      pixel_valid <= pixel_enable & display_enable;
      underrun    <= starving & display_enable;
      if (pixel_enable) begin
        if (!display_enable || !emit) begin
          pixel_color <= '0;
        end else if (emit_conceal || (emit_blink && blink_phase)) begin
          pixel_color <= emit_bg;
        end else begin
          pixel_color <= emit_bit ? emit_fg : emit_bg;
        end
      end
    end
  end

endmodule

// File: tb/tb_pixel_serializer.sv
// Self-checking bench for pixel_serializer: directed vector table, corner-case
// sequences and randomized traffic against a row-level reference model.
module tb_pixel_serializer;

  localparam int BF = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       pixel_enable;
  logic       display_enable;
  logic       frame_start;
  logic       load_valid;
  logic       load_ready;
  logic [7:0] row_pixels;
  logic [2:0] foreground;
  logic [2:0] background;
  logic       blink;
  logic       conceal;
  logic       pixel_valid;
  logic [2:0] pixel_color;
  logic       underrun;

  int checks = 0;
  int errors = 0;

  pixel_serializer #(
    .PIXELS_PER_CHAR(8),
    .COLOR_WIDTH    (3),
    .BLINK_FRAMES   (BF)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .pixel_enable   (pixel_enable),
    .display_enable (display_enable),
    .frame_start    (frame_start),
    .load_valid     (load_valid),
    .load_ready     (load_ready),
    .row_pixels     (row_pixels),
    .foreground     (foreground),
    .background     (background),
    .blink          (blink),
    .conceal        (conceal),
    .pixel_valid    (pixel_valid),
    .pixel_color    (pixel_color),
    .underrun       (underrun)
  );

  always #5 clk = ~clk;

  // Reference model: rows accepted but not fully emitted, oldest first.
  typedef struct {
    logic [7:0] px;
    logic [2:0] fg;
    logic [2:0] bg;
    logic       bl;
    logic       co;
    int         pos;
    bit         in_sh;
  } row_t;

  row_t rows[$];
  int   frames;
  logic [2:0] exp_color;
  logic exp_valid;
  logic exp_under;
  logic exp_ready;

  typedef struct {
    logic       pe;
    logic       de;
    logic       lv;
    logic [7:0] row;
    logic [2:0] fg;
    logic [2:0] bg;
    logic [2:0] color;
    logic       valid;
    logic       ready;
    logic       under;
  } vec_t;

  vec_t tbl[11];

  function automatic bit modelReady();
    return rows.size() == 0 || (rows.size() == 1 && rows[0].in_sh);
  endfunction

  task automatic compare(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic checkOutput(input string tag);
    compare({tag, ".color"}, pixel_color, exp_color);
    compare({tag, ".valid"}, pixel_valid, exp_valid);
    compare({tag, ".underrun"}, underrun, exp_under);
    compare({tag, ".ready"}, load_ready, exp_ready);
  endtask

  task automatic modelReset();
    rows.delete();
    frames    = 0;
    exp_color = 3'd0;
    exp_valid = 1'b0;
    exp_under = 1'b0;
    exp_ready = 1'b1;
  endtask

  task automatic applyStimulus(input logic pe, input logic de, input logic fs, input logic lv,
                               input logic [7:0] rp, input logic [2:0] f, input logic [2:0] b,
                               input logic bl, input logic co, input string tag);
    bit   rdy;
    bit   phase;
    row_t r;
    logic [2:0] col;
    pixel_enable   = pe;
    display_enable = de;
    frame_start    = fs;
    load_valid     = lv;
    row_pixels     = rp;
    foreground     = f;
    background     = b;
    blink          = bl;
    conceal        = co;
    rdy   = modelReady();
    phase = ((frames / BF) % 2) == 1;
    exp_valid = pe & de;
    exp_under = 1'b0;
    if (pe) begin
      if (rows.size() > 0) begin
        r = rows[0];
        if (r.co || (r.bl && phase)) col = r.bg;
        else col = r.px[7 - r.pos] ? r.fg : r.bg;
        r.pos++;
        r.in_sh = 1'b1;
        if (r.pos == 8) begin
          void'(rows.pop_front());
          if (rows.size() > 0) begin
            r = rows[0];
            r.in_sh = 1'b1;
            rows[0] = r;
          end
        end else begin
          rows[0] = r;
        end
        exp_color = de ? col : 3'd0;
      end else begin
        exp_color = 3'd0;
        exp_under = de;
      end
    end
    if (fs) frames++;
    if (lv && rdy) begin
      r.px = rp; r.fg = f; r.bg = b; r.bl = bl; r.co = co; r.pos = 0; r.in_sh = 1'b0;
      rows.push_back(r);
    end
    exp_ready = modelReady();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic idle(input string tag);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, tag);
  endtask

  task automatic doReset();
    pixel_enable = 1'b0; display_enable = 1'b1; frame_start = 1'b0; load_valid = 1'b0;
    reset = 1'b1;
    modelReset();
    #1;
    checkOutput("reset_async");
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    tbl[0]  = '{1'b0, 1'b1, 1'b1, 8'hA5, 3'd7, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0};
    tbl[1]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[5]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[7]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd1, 1'b1, 1'b1, 1'b0};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd7, 1'b1, 1'b1, 1'b0};
    tbl[9]  = '{1'b1, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd0, 1'b1, 1'b1, 1'b1};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 8'hA5, 3'd7, 3'd1, 3'd0, 1'b0, 1'b1, 1'b0};

    reset = 1'b0;
    pixel_enable = 1'b0; display_enable = 1'b0; frame_start = 1'b0; load_valid = 1'b0;
    row_pixels = 8'h00; foreground = 3'd0; background = 3'd0; blink = 1'b0; conceal = 1'b0;
    #3;
    doReset();

    // Row A5 then underrun on the 9th pixel
    for (int i = 0; i < 11; i++) begin
      applyStimulus(tbl[i].pe, tbl[i].de, 1'b0, tbl[i].lv, tbl[i].row, tbl[i].fg, tbl[i].bg,
                    1'b0, 1'b0, $sformatf("vec%0d", i));
      compare($sformatf("tbl%0d.color", i), pixel_color, tbl[i].color);
      compare($sformatf("tbl%0d.valid", i), pixel_valid, tbl[i].valid);
      compare($sformatf("tbl%0d.ready", i), load_ready, tbl[i].ready);
      compare($sformatf("tbl%0d.underrun", i), underrun, tbl[i].under);
    end

    // Back-to-back FF then 00: 16 contiguous pixels, no underrun
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd6, 3'd1, 1'b0, 1'b0, "b2b_load");
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, (i >= 1 && i <= 3), 8'h00, 3'd6, 3'd1, 1'b0, 1'b0, "b2b");
      compare($sformatf("b2b%0d.color", i), pixel_color, (i < 8) ? 6 : 1);
      compare($sformatf("b2b%0d.underrun", i), underrun, 0);
    end

    // Blink with BLINK_FRAMES=2: 3 -> 4 after two frames, back to 3 after two more
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_load");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_p1");
    compare("blink.phase0", pixel_color, 3);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_f1");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_f2");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_p4");
    compare("blink.phase1", pixel_color, 4);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_f3");
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_f4");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'hFF, 3'd3, 3'd4, 1'b1, 1'b0, "blk_p7");
    compare("blink.phase0_again", pixel_color, 3);

    // Conceal, then blanking mid-row still consumes bits
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd6, 3'd2, 1'b0, 1'b1, "cc_load");
    for (int i = 0; i < 9; i++) begin
      applyStimulus(1'b1, !(i >= 3 && i <= 5), 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, "cc");
      if (i < 8) begin
        compare($sformatf("cc%0d.color", i), pixel_color, (i >= 3 && i <= 5) ? 0 : 2);
        compare($sformatf("cc%0d.valid", i), pixel_valid, (i >= 3 && i <= 5) ? 0 : 1);
      end else begin
        compare("cc.underrun_after_row", underrun, 1);
      end
    end

    // Reset at pixel 4 discards the row; next row restarts at bit 7
    doReset();
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 3'd5, 3'd2, 1'b0, 1'b0, "mr_load");
    for (int i = 0; i < 4; i++)
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, "mr_px");
    compare("midreset.pre_color", pixel_color, 5);
    doReset();
    compare("midreset.color_zero", pixel_color, 0);
    applyStimulus(1'b0, 1'b1, 1'b0, 1'b1, 8'h80, 3'd5, 3'd2, 1'b0, 1'b0, "mr_reload");
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, "mr_first");
    compare("midreset.first_fg", pixel_color, 5);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 3'd0, 3'd0, 1'b0, 1'b0, "mr_second");
    compare("midreset.second_bg", pixel_color, 2);
    idle("mr_idle");

    // Randomized traffic against the model
    doReset();
    for (int i = 0; i < 800; i++) begin
      applyStimulus($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 8, $urandom_range(0, 9) == 0,
                    $urandom_range(0, 1) == 1, 8'($urandom), 3'($urandom), 3'($urandom),
                    $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
